// File: rtl/wb_regfile.sv
`default_nettype none
// ============================================================================
// Module   : wb_regfile
// Purpose  : EX/WB pipeline register and 8-entry register file for the 8-bit
//            pipelined processor. Latches the ALU result and destination,
//            commits it to the register file one cycle later, drives the
//            EX-stage forwarding triplet and serves the decode read port.
// Ports    : clk          - system clock, rising edge
//            reset        - asynchronous, active-high reset
//            Ans          - ALU result from EX
//            RD_EX        - destination register of the EX instruction
//            Reg_Write_EX - EX instruction writes a register
//            Hold         - stall, freezes the EX/WB register
//            Flush        - replaces the incoming EX entry with a bubble
//            RS           - decode-stage read address
//            Read_Data    - register file contents at RS
//            Write_Data   - WB-stage data (forwarding and commit)
//            RD           - WB-stage destination register
//            Reg_Write    - WB-stage write enable
//            Write_Count  - committed register writes, wraps modulo 256
// Options  : WB_WRITE_THROUGH_EN - when defined, Read_Data bypasses the
//            in-flight WB write if RS matches RD and Reg_Write is set.
// Revision : 1.0 - initial release
// ============================================================================
module wb_regfile #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 3,
    parameter int NUM_REGS = 8   // must equal 2**ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] Ans,
    input  logic [ADDR_W-1:0] RD_EX,
    input  logic              Reg_Write_EX,
    input  logic              Hold,
    input  logic              Flush,
    input  logic [ADDR_W-1:0] RS,
    output logic [DATA_W-1:0] Read_Data,
    output logic [DATA_W-1:0] Write_Data,
    output logic [ADDR_W-1:0] RD,
    output logic              Reg_Write,
    output logic [7:0]        Write_Count
);

    logic [DATA_W-1:0] r_wb_data;
    logic [ADDR_W-1:0] r_wb_rd;
    logic              r_wb_we;
    logic [7:0]        r_write_count;
    logic [DATA_W-1:0] r_regs [NUM_REGS];
    logic [DATA_W-1:0] w_read_data;

    // EX/WB pipeline register. Flush only clears the write enable so the
    // forwarding data/address stay stable; it takes priority over Hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wb_data <= '0;
            r_wb_rd   <= '0;
            r_wb_we   <= 1'b0;
        end else if (Flush) begin
            r_wb_we   <= 1'b0;
        end else if (!Hold) begin
            r_wb_data <= Ans;
            r_wb_rd   <= RD_EX;
            r_wb_we   <= Reg_Write_EX;
        end
    end

    // Commit stage. The entry sitting in WB is written every edge it is
    // valid, independent of Hold/Flush, so a held entry rewrites itself and
    // bumps the counter each held cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_write_count <= 8'd0;
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= DATA_W'(i);
            end
        end else if (r_wb_we) begin
            r_regs[r_wb_rd] <= r_wb_data;
            r_write_count   <= r_write_count + 8'd1;
        end
    end

`ifdef WB_WRITE_THROUGH_EN
    // Decode-stage bypass of the in-flight WB write.
    always_comb begin
        w_read_data = r_regs[RS];
        if (r_wb_we && (RS == r_wb_rd)) begin
            w_read_data = r_wb_data;
        end
    end
`else
    // Plain read; the RS==RD hazard is resolved by the ALU forwarding path.
    always_comb begin
        w_read_data = r_regs[RS];
    end
`endif

    assign Read_Data   = w_read_data;
    assign Write_Data  = r_wb_data;
    assign RD          = r_wb_rd;
    assign Reg_Write   = r_wb_we;
    assign Write_Count = r_write_count;

endmodule
`default_nettype wire

// File: tb/tb_wb_regfile.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_regfile
// Purpose  : Self-checking bench for wb_regfile. Expected WB outputs are
//            pushed to a queue when each EX entry is driven and popped after
//            the following clock edge; read-port results come from a small
//            reference model of the register file.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_regfile;

    logic       clk;
    logic       reset;
    logic [7:0] Ans;
    logic [2:0] RD_EX;
    logic       Reg_Write_EX;
    logic       Hold;
    logic       Flush;
    logic [2:0] RS;
    logic [7:0] Read_Data;
    logic [7:0] Write_Data;
    logic [2:0] RD;
    logic       Reg_Write;
    logic [7:0] Write_Count;

    int checks;
    int errors;

    // Reference model state
    logic [7:0] m_regs [8];
    logic [7:0] m_wd;
    logic [2:0] m_rd;
    logic       m_we;
    logic [7:0] m_cnt;

    // Scoreboard entries: {Write_Data, RD, Reg_Write, Write_Count}
    logic [19:0] exp_q [$];

    wb_regfile #(
        .DATA_W   (8),
        .ADDR_W   (3),
        .NUM_REGS (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .Ans          (Ans),
        .RD_EX        (RD_EX),
        .Reg_Write_EX (Reg_Write_EX),
        .Hold         (Hold),
        .Flush        (Flush),
        .RS           (RS),
        .Read_Data    (Read_Data),
        .Write_Data   (Write_Data),
        .RD           (RD),
        .Reg_Write    (Reg_Write),
        .Write_Count  (Write_Count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_regs[i] = 8'(i);
        m_wd  = 8'd0;
        m_rd  = 3'd0;
        m_we  = 1'b0;
        m_cnt = 8'd0;
        exp_q.delete();
    endtask

    function automatic logic [7:0] model_read(input logic [2:0] rs);
`ifdef WB_WRITE_THROUGH_EN
        if (m_we && rs == m_rd) return m_wd;
`endif
        return m_regs[rs];
    endfunction

    // One pipeline cycle: drive EX inputs on the falling edge, predict the
    // post-edge WB state, then compare just after the rising edge.
    task automatic cycle(input logic [7:0] a, input logic [2:0] rd, input logic we,
                         input logic hold, input logic flush);
        logic [19:0] e;
        @(negedge clk);
        Ans = a; RD_EX = rd; Reg_Write_EX = we; Hold = hold; Flush = flush;
        if (m_we) begin
            m_regs[m_rd] = m_wd;
            m_cnt        = m_cnt + 8'd1;
        end
        if (flush) m_we = 1'b0;
        else if (!hold) begin
            m_wd = a; m_rd = rd; m_we = we;
        end
        exp_q.push_back({m_wd, m_rd, m_we, m_cnt});
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check("wb", 32'({Write_Data, RD, Reg_Write, Write_Count}), 32'(e));
        end
    endtask

    task automatic read_chk(input string tag, input logic [2:0] rs, input logic [7:0] exp);
        RS = rs;
        #1;
        check(tag, 32'(Read_Data), 32'(exp));
    endtask

    logic [7:0] cnt0;

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1;
        Ans = '0; RD_EX = '0; Reg_Write_EX = 1'b0; Hold = 1'b0; Flush = 1'b0; RS = '0;
        model_reset();
        #2;

        // Reset state
        for (int i = 0; i < 8; i++) read_chk("rst_rd", 3'(i), 8'(i));
        check("rst_we", 32'(Reg_Write), 32'd0);
        check("rst_cnt", 32'(Write_Count), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Write then read
        cycle(8'h5A, 3'd3, 1'b1, 1'b0, 1'b0);
        check("wb_5a", 32'({Write_Data, RD, Reg_Write}), 32'({8'h5A, 3'd3, 1'b1}));
        cycle(8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
        read_chk("rd_5a", 3'd3, 8'h5A);
        check("cnt_1", 32'(Write_Count), 32'd1);

        // Forwarding-window read
        cycle(8'hC3, 3'd3, 1'b1, 1'b0, 1'b0);
`ifdef WB_WRITE_THROUGH_EN
        read_chk("fwd_win", 3'd3, 8'hC3);
`else
        read_chk("fwd_win", 3'd3, 8'h5A);
`endif
        cycle(8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
        read_chk("rd_c3", 3'd3, 8'hC3);

        // Hold then Flush
        cycle(8'h11, 3'd5, 1'b1, 1'b0, 1'b0);
        cnt0 = Write_Count;
        for (int i = 0; i < 3; i++) cycle(8'h77, 3'd1, 1'b1, 1'b1, 1'b0);
        check("hold_wb", 32'({Write_Data, RD, Reg_Write}), 32'({8'h11, 3'd5, 1'b1}));
        check("hold_cnt", 32'(Write_Count), 32'(cnt0 + 8'd3));
        read_chk("hold_r5", 3'd5, 8'h11);
        read_chk("hold_r1", 3'd1, 8'h01);
        cycle(8'h77, 3'd1, 1'b1, 1'b1, 1'b1);
        check("flush_we", 32'(Reg_Write), 32'd0);
        check("flush_keep", 32'({Write_Data, RD}), 32'({8'h11, 3'd5}));
        cycle(8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
        check("flush_cnt", 32'(Write_Count), 32'(cnt0 + 8'd4));

        // Randomised traffic against the model
        for (int i = 0; i < 60; i++) begin
            cycle(8'($urandom_range(255)), 3'($urandom_range(7)), 1'($urandom_range(1)),
                  ($urandom_range(4) == 0), ($urandom_range(5) == 0));
            RS = 3'($urandom_range(7));
            read_chk("rnd_rd", RS, model_read(RS));
        end

        // Write_Count wrap from reset
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        #1;
        check("wrap_rst", 32'(Write_Count), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 256; i++) cycle(8'(i), 3'(i), 1'b1, 1'b0, 1'b0);
        check("wrap_255", 32'(Write_Count), 32'd255);
        cycle(8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
        check("wrap_0", 32'(Write_Count), 32'd0);
        read_chk("wrap_r7", 3'd7, 8'hFF);

        // Reset mid-operation discards the pending WB write
        cycle(8'hFF, 3'd2, 1'b1, 1'b0, 1'b0);
        check("mid_pend", 32'({Write_Data, RD, Reg_Write}), 32'({8'hFF, 3'd2, 1'b1}));
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check("mid_we", 32'(Reg_Write), 32'd0);
        check("mid_cnt", 32'(Write_Count), 32'd0);
        read_chk("mid_r2", 3'd2, 8'h02);
        @(negedge clk);
        reset = 1'b0;
        Reg_Write_EX = 1'b0;
        @(posedge clk);
        #1;
        read_chk("post_r2", 3'd2, 8'h02);
        check("post_cnt", 32'(Write_Count), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Writer end of the EX-to-WB forwarding interface in the 8-bit pipelined processor.
- Latches the ALU result and destination into the EX/WB pipeline register and commits it to an 8-entry register file.
- Drives the forwarding triplet (Write_Data, RD, Reg_Write) consumed by the EX-stage ALU.
- Provides the decode-stage read port that supplies the ALU's Read_Data operand.

Parameters:
- DATA_W, 8, register and datapath width in bits
- ADDR_W, 3, register address width in bits
- NUM_REGS, 8, number of registers; must equal 2**ADDR_W

Ports:
- clk  input  1  single system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- Ans  input  DATA_W  ALU result from the EX stage
- RD_EX  input  ADDR_W  destination register of the instruction in EX
- Reg_Write_EX  input  1  EX instruction writes a register
- Hold  input  1  stall; freezes the EX/WB register
- Flush  input  1  inserts a bubble into WB
- RS  input  ADDR_W  decode-stage read address
- Read_Data  output  DATA_W  register file contents at RS
- Write_Data  output  DATA_W  WB-stage data (forwarding and commit)
- RD  output  ADDR_W  WB-stage destination register
- Reg_Write  output  1  WB-stage write enable
- Write_Count  output  8  number of committed register writes, wrapping

Behaviour:
- Reset (asynchronous, takes effect immediately and regardless of clk):
  - Write_Data=0, RD=0, Reg_Write=0, Write_Count=0.
  - Register i is loaded with the value i (zero-extended to DATA_W).
  - A reset asserted mid-operation discards any pending WB write.
- EX/WB register, on each rising clk edge while reset is low:
  - Flush=1: Reg_Write<=0; RD and Write_Data keep their values. Flush wins over Hold.
  - Hold=1 and Flush=0: all three WB registers keep their values.
  - Otherwise: Write_Data<=Ans, RD<=RD_EX, Reg_Write<=Reg_Write_EX.
- Latency: an instruction presented on the EX inputs appears on the WB outputs one cycle later. It commits to the file at the next following edge.
- Commit, on each rising edge where the current Reg_Write=1:
  - regs[RD]<=Write_Data and Write_Count<=Write_Count+1 (modulo 256, 255 wraps to 0).
  - Commit happens even when Hold=1. A held WB entry therefore rewrites the same value each held cycle and Write_Count increments each such cycle.
  - Flush does not cancel the commit of the entry currently in WB. It only replaces the incoming entry with a bubble.
- All registers, including register 0, are writable; there is no hardwired zero.
- Read port:
  - Read_Data is combinational, equal to regs[RS].
  - When RS==RD and Reg_Write=1, Read_Data still shows the old contents. The ALU's forwarding path resolves that hazard.
- The forwarding outputs are registered values, glitch-free, valid for the whole cycle.

Optional Feature:
- Macro: WB_WRITE_THROUGH_EN
- Defined: Read_Data = Write_Data whenever RS==RD and Reg_Write=1; otherwise regs[RS]. This gives decode-stage bypass of the in-flight WB write.
- Undefined: Read_Data = regs[RS] always, as in the read-port rule above.

Test Plan:
- Reset check: assert reset -> Read_Data equals RS for RS=0..7; Reg_Write=0; Write_Count=0.
- Write then read:
  - Cycle 0 inputs: Ans=8'h5A, RD_EX=3, Reg_Write_EX=1.
  - Edge 1: WB outputs show 5A/3/1.
  - After edge 2: RS=3 reads 8'h5A and Write_Count=1.
- Forwarding-window read: RS=3 while WB holds 8'hC3 to reg 3 (old value 8'h5A) -> Read_Data=8'h5A without the macro, 8'hC3 with WB_WRITE_THROUGH_EN.
- Hold then Flush:
  - Hold=1 for 3 cycles with WB holding 8'h11 to reg 5 -> WB outputs frozen, regs[5]=8'h11, Write_Count+3.
  - Next: Hold=1 with Flush=1 -> Reg_Write=0 next cycle.
- Write_Count wrap: 256 consecutive writes from reset -> Write_Count returns to 0.
- Reset mid-operation: assert reset asynchronously between edges while Reg_Write=1 to reg 2 with data 8'hFF -> regs[2]=2, Reg_Write=0 immediately, no commit at the next edge.
